// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shared data-memory responder for NCORES requesting cores.
// Arbitrates among level requests, latches the winner, performs one access
// on an internal 2^WIDTH-word single-port RAM and returns a one-cycle ack.
//
// Ports:
//   Clk    in   system clock, rising edge
//   Rst    in   asynchronous reset, active-high
//   req    in   [NCORES]        per-core request, held until ack
//   wen    in   [NCORES]        per-core write enable (1 = write)
//   addr   in   [NCORES*WIDTH]  core i address at [i*WIDTH +: WIDTH]
//   wdata  in   [NCORES*WIDTH]  core i write data at [i*WIDTH +: WIDTH]
//   ack    out  [NCORES]        one-hot completion pulse, one cycle
//   rdata  out  [WIDTH]         last read data, valid while ack is high
//   busy   out                  high whenever the FSM is not idle
//
// Configuration macro: DMEM_RR_EN
//   defined   -> round-robin arbitration starting after the last grant
//   undefined -> fixed priority, lowest core index wins
module dmem_arbiter #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NCORES = 4
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic [NCORES-1:0]        req,
  input  logic [NCORES-1:0]        wen,
  input  logic [NCORES*WIDTH-1:0]  addr,
  input  logic [NCORES*WIDTH-1:0]  wdata,
  output logic [NCORES-1:0]        ack,
  output logic [WIDTH-1:0]         rdata,
  output logic                     busy
);

  localparam int unsigned IDXW  = (NCORES > 1) ? $clog2(NCORES) : 1;
  localparam int unsigned DEPTH = 1 << WIDTH;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state, next_state;
  logic              gnt_valid;
  logic [IDXW-1:0]   gnt_idx;
  logic [IDXW-1:0]   cand;
  logic [WIDTH-1:0]  sel_addr, sel_wdata;
  logic              sel_wen;
  logic              grant_en, access_en;

  logic [IDXW-1:0]   lat_idx;
  logic [WIDTH-1:0]  lat_addr, lat_wdata;
  logic              lat_wen;

  logic [WIDTH-1:0]  mem [DEPTH];

`ifdef DMEM_RR_EN
  logic [IDXW-1:0]   ptr;

  // Round-robin: nearest requester after ptr wins (descending loop, last hit wins)
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = NCORES; k >= 1; k--) begin
      cand = IDXW'((32'(ptr) + 32'(k)) % 32'(NCORES));
      if (req[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
  end
`else
  // Fixed priority: lowest index wins (descending loop, last hit wins)
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = NCORES - 1; i >= 0; i--) begin
      cand = IDXW'(i);
      if (req[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
  end
`endif

  // Mux the granted core's request fields
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wen   = 1'b0;
    for (int i = 0; i < NCORES; i++) begin
      if (gnt_idx == IDXW'(i)) begin
        sel_addr  = addr[i*WIDTH +: WIDTH];
        sel_wdata = wdata[i*WIDTH +: WIDTH];
        sel_wen   = wen[i];
      end
    end
  end

  // State register
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (gnt_valid) next_state = ACCESS;
      ACCESS:  next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Control decode
  always_comb begin
    grant_en  = 1'b0;
    access_en = 1'b0;
    case (state)
      IDLE:    grant_en  = gnt_valid;
      ACCESS:  access_en = 1'b1;
      default: ;
    endcase
  end

  // Request latch, ack/rdata/busy registers and arbitration pointer
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      lat_idx   <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_wen   <= 1'b0;
      ack       <= '0;
      rdata     <= '0;
      busy      <= 1'b0;
`ifdef DMEM_RR_EN
      ptr       <= IDXW'(NCORES - 1);
`endif
    end else begin
      busy <= (next_state != IDLE);
      ack  <= '0;
      if (grant_en) begin
        lat_idx   <= gnt_idx;
        lat_addr  <= sel_addr;
        lat_wdata <= sel_wdata;
        lat_wen   <= sel_wen;
`ifdef DMEM_RR_EN
        ptr       <= gnt_idx;
`endif
      end
      if (access_en) begin
        ack <= NCORES'(1) << lat_idx;
        if (!lat_wen) rdata <= mem[lat_addr];
      end
    end
  end

  // RAM write port; contents are not reset
  always_ff @(posedge Clk) begin
    if (!Rst && access_en && lat_wen) mem[lat_addr] <= lat_wdata;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter.
module tb_dmem_arbiter;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned NCORES = 4;

  logic                    Clk = 1'b0;
  logic                    Rst = 1'b0;
  logic [NCORES-1:0]       req = '0;
  logic [NCORES-1:0]       wen = '0;
  logic [NCORES*WIDTH-1:0] addr = '0;
  logic [NCORES*WIDTH-1:0] wdata = '0;
  logic [NCORES-1:0]       ack;
  logic [WIDTH-1:0]        rdata;
  logic                    busy;

  int tests = 0;
  int fails = 0;

  dmem_arbiter #(.WIDTH(WIDTH), .NCORES(NCORES)) dut (
    .Clk(Clk), .Rst(Rst), .req(req), .wen(wen), .addr(addr),
    .wdata(wdata), .ack(ack), .rdata(rdata), .busy(busy)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_core(input int c, input logic r, input logic w,
                          input logic [7:0] a, input logic [7:0] d);
    req[c] = r;
    wen[c] = w;
    addr[c*WIDTH +: WIDTH]  = a;
    wdata[c*WIDTH +: WIDTH] = d;
  endtask

  task automatic apply_reset();
    req = '0;
    #2 Rst = 1'b1;
    #10 Rst = 1'b0;
    tick();
  endtask

  // Stimulus-only helper: full write transaction through core c
  task automatic mem_write(input int c, input logic [7:0] a, input logic [7:0] d);
    set_core(c, 1'b1, 1'b1, a, d);
    tick();
    tick();
    req[c] = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    apply_reset();
    tests++; if (ack !== 4'b0000) begin fails++; $display("FAIL reset_ack got %b exp 0000", ack); end
    tests++; if (rdata !== 8'h00) begin fails++; $display("FAIL reset_rdata got %h exp 00", rdata); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
  endtask

  task automatic test_reset_mid_access();
    mem_write(0, 8'h10, 8'h5A);
    set_core(0, 1'b1, 1'b1, 8'h10, 8'hAA);
    tick();
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL mid_busy_pre got %b exp 1", busy); end
    #1 Rst = 1'b1;
    #1;
    tests++; if (ack !== 4'b0000) begin fails++; $display("FAIL mid_ack got %b exp 0000", ack); end
    tests++; if (rdata !== 8'h00) begin fails++; $display("FAIL mid_rdata got %h exp 00", rdata); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_busy got %b exp 0", busy); end
    req = '0;
    #10 Rst = 1'b0;
    tick();
    tests++; if (ack !== 4'b0000) begin fails++; $display("FAIL mid_ack_after got %b exp 0000", ack); end
    set_core(0, 1'b1, 1'b0, 8'h10, 8'h00);
    tick();
    tick();
    tests++; if (rdata !== 8'h5A) begin fails++; $display("FAIL mid_no_write got %h exp 5a", rdata); end
    req = '0;
    tick();
  endtask

  task automatic test_write_read();
    set_core(1, 1'b1, 1'b1, 8'h20, 8'h55);
    tick();
    tests++; if (busy !== 1'b1 || ack !== 4'b0000) begin fails++; $display("FAIL wr_grant got busy=%b ack=%b exp busy=1 ack=0000", busy, ack); end
    tick();
    tests++; if (ack !== 4'b0010) begin fails++; $display("FAIL wr_ack got %b exp 0010", ack); end
    req[1] = 1'b0;
    tick();
    tests++; if (ack !== 4'b0000 || busy !== 1'b0) begin fails++; $display("FAIL wr_clear got ack=%b busy=%b exp 0000/0", ack, busy); end
    set_core(1, 1'b1, 1'b0, 8'h20, 8'h00);
    tick();
    tick();
    tests++; if (ack !== 4'b0010) begin fails++; $display("FAIL rd_ack got %b exp 0010", ack); end
    tests++; if (rdata !== 8'h55) begin fails++; $display("FAIL rd_data got %h exp 55", rdata); end
    req[1] = 1'b0;
    tick();
    tests++; if (ack !== 4'b0000) begin fails++; $display("FAIL rd_clear got %b exp 0000", ack); end
  endtask

`ifdef DMEM_RR_EN
  task automatic test_round_robin();
    logic [3:0] exp;
    apply_reset();
    for (int c = 0; c < 4; c++) set_core(c, 1'b1, 1'b0, 8'(8'h50 + c), 8'h00);
    for (int k = 1; k <= 15; k++) begin
      tick();
      exp = (k % 3 == 2) ? (4'b0001 << (((k - 2) / 3) % 4)) : 4'b0000;
      tests++; if (ack !== exp) begin fails++; $display("FAIL rr_tick%0d got %b exp %b", k, ack, exp); end
      if (k == 14) req = '0;
    end
    tick();
  endtask
`else
  task automatic test_fixed_priority();
    logic [3:0] exp;
    apply_reset();
    set_core(0, 1'b1, 1'b0, 8'h60, 8'h00);
    set_core(2, 1'b1, 1'b0, 8'h62, 8'h00);
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k == 11)          exp = 4'b0100;
      else if (k % 3 == 2)  exp = 4'b0001;
      else                  exp = 4'b0000;
      tests++; if (ack !== exp) begin fails++; $display("FAIL fp_tick%0d got %b exp %b", k, ack, exp); end
      if (k == 8) req[0] = 1'b0;
    end
    req = '0;
    tick();
  endtask
`endif

  task automatic test_withdrawal();
    mem_write(0, 8'h30, 8'h77);
    mem_write(0, 8'h31, 8'h88);
    set_core(3, 1'b1, 1'b0, 8'h30, 8'h00);
    tick();
    addr[3*WIDTH +: WIDTH] = 8'h31;
    req[3] = 1'b0;
    tick();
    tests++; if (ack !== 4'b1000) begin fails++; $display("FAIL wd_ack got %b exp 1000", ack); end
    tests++; if (rdata !== 8'h77) begin fails++; $display("FAIL wd_rdata got %h exp 77", rdata); end
    for (int k = 0; k < 4; k++) begin
      tick();
      tests++; if (ack !== 4'b0000 || busy !== 1'b0) begin fails++; $display("FAIL wd_idle%0d got ack=%b busy=%b exp 0000/0", k, ack, busy); end
    end
  endtask

  task automatic test_write_keeps_rdata();
    mem_write(1, 8'h40, 8'h11);
    set_core(0, 1'b1, 1'b0, 8'h40, 8'h00);
    tick();
    tick();
    tests++; if (rdata !== 8'h11) begin fails++; $display("FAIL wk_read got %h exp 11", rdata); end
    req[0] = 1'b0;
    tick();
    set_core(2, 1'b1, 1'b1, 8'h41, 8'h22);
    tick();
    tick();
    tests++; if (ack !== 4'b0100 || rdata !== 8'h11) begin fails++; $display("FAIL wk_write got ack=%b rdata=%h exp 0100/11", ack, rdata); end
    req[2] = 1'b0;
    tick();
    tests++; if (rdata !== 8'h11) begin fails++; $display("FAIL wk_after got %h exp 11", rdata); end
    set_core(3, 1'b1, 1'b0, 8'h41, 8'h00);
    tick();
    tick();
    tests++; if (rdata !== 8'h22) begin fails++; $display("FAIL wk_readback got %h exp 22", rdata); end
    req = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_reset_mid_access();
    test_write_read();
`ifdef DMEM_RR_EN
    test_round_robin();
`else
    test_fixed_priority();
`endif
    test_withdrawal();
    test_write_keeps_rdata();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
